// File: rtl/simulation_end_pkg.sv
// Shared types and helpers for the end-of-simulation sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package simulation_end_pkg;

    typedef enum logic [1:0] {
        RUNNING   = 2'd0,
        DRAINING  = 2'd1,
        FINISHING = 2'd2,
        DONE      = 2'd3
    } end_state_e;

    // Reported instead of a zero code when the UART never went quiet.
    localparam int FORCED_FAIL_CODE = 1;

    // Index width that never collapses to zero bits for a single source.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/simulation_end_controller_if.sv
// Request/status bundle between the end-request sources, UART and the sequencer.
// Latency: n/a (wires only).
// Backpressure: none; requests are level signals held by their sources.
interface simulation_end_controller_if #(
    parameter int REQUESTER_COUNT = 4,
    parameter int EXIT_CODE_WIDTH = 8
);
    import simulation_end_pkg::*;

    localparam int IDX_W = idx_width(REQUESTER_COUNT);

    logic [REQUESTER_COUNT-1:0]                 end_request;
    logic [REQUESTER_COUNT*EXIT_CODE_WIDTH-1:0] end_exit_codes;
    logic                                       uart_busy;
    logic                                       ending;
    logic                                       finish_pulse;
    logic [IDX_W-1:0]                           winner_index;
    logic [EXIT_CODE_WIDTH-1:0]                 exit_code;
    logic                                       drain_timeout;
    logic                                       late_request;

    // Bench side: raises requests and reports UART activity.
    modport master (
        output end_request, end_exit_codes, uart_busy,
        input  ending, finish_pulse, winner_index, exit_code, drain_timeout, late_request
    );

    // Sequencer side.
    modport slave (
        input  end_request, end_exit_codes, uart_busy,
        output ending, finish_pulse, winner_index, exit_code, drain_timeout, late_request
    );

endinterface

// File: rtl/simulation_end_priority_picker.sv
// Lowest-set-bit encoder: bit 0 is the highest-priority source.
// Latency: combinational.
// Backpressure: none.
module simulation_end_priority_picker
    import simulation_end_pkg::*;
#(
    parameter  int REQUESTER_COUNT = 4,
    localparam int IW              = idx_width(REQUESTER_COUNT)
) (
    input  logic [REQUESTER_COUNT-1:0] req_i,
    output logic                       vld_o,
    output logic [IW-1:0]              idx_o
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        vld_o = |req_i;
        idx_o = '0;
        for (int i = REQUESTER_COUNT - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/simulation_end_controller.sv
// Latches one end request, drains the UART until quiet (bounded), then pulses finish.
// Latency: finish after QUIET_TICKS edges past the request edge at best, DRAIN_LIMIT_TICKS at worst.
// Backpressure: none; extra requests are only flagged, never queued.
module simulation_end_controller
    import simulation_end_pkg::*;
#(
    parameter int REQUESTER_COUNT   = 4,
    parameter int EXIT_CODE_WIDTH   = 8,
    parameter int QUIET_TICKS       = 16,
    parameter int DRAIN_LIMIT_TICKS = 1024
) (
    input logic                         clock,
    input logic                         reset,
    simulation_end_controller_if.slave  bus
);

    localparam int IW = idx_width(REQUESTER_COUNT);
    localparam int QW = $clog2(QUIET_TICKS + 1);
    localparam int DW = $clog2(DRAIN_LIMIT_TICKS + 1);

    localparam logic [QW-1:0]              QUIET_LAST = QW'(QUIET_TICKS - 1);
    localparam logic [DW-1:0]              DRAIN_LAST = DW'(DRAIN_LIMIT_TICKS - 1);
    localparam logic [EXIT_CODE_WIDTH-1:0] FORCED     = EXIT_CODE_WIDTH'(FORCED_FAIL_CODE);

    end_state_e                 state_q;
    logic                       ending_q;
    logic                       finish_q;
    logic [IW-1:0]              winner_q;
    logic [EXIT_CODE_WIDTH-1:0] code_q;
    logic                       timeout_q;
    logic                       late_q;
    logic [QW-1:0]              quiet_q;
    logic [DW-1:0]              drain_q;

    logic                       pick_vld;
    logic [IW-1:0]              pick_idx;
    logic [EXIT_CODE_WIDTH-1:0] pick_code;

    simulation_end_priority_picker #(
        .REQUESTER_COUNT (REQUESTER_COUNT)
    ) u_picker (
        .req_i (bus.end_request),
        .vld_o (pick_vld),
        .idx_o (pick_idx)
    );

    assign pick_code = bus.end_exit_codes[pick_idx*EXIT_CODE_WIDTH +: EXIT_CODE_WIDTH];

    // Sequencer: latch winner, drain UART, pulse finish, then park until reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RUNNING;
            ending_q  <= 1'b0;
            finish_q  <= 1'b0;
            winner_q  <= '0;
            code_q    <= '0;
            timeout_q <= 1'b0;
            late_q    <= 1'b0;
            quiet_q   <= '0;
            drain_q   <= '0;
        end else begin
            finish_q <= 1'b0;
            case (state_q)
                RUNNING: begin
                    if (pick_vld) begin
                        winner_q <= pick_idx;
                        code_q   <= pick_code;
                        ending_q <= 1'b1;
                        quiet_q  <= '0;
                        drain_q  <= '0;
                        state_q  <= DRAINING;
                    end
                end
                DRAINING: begin
                    // Quiet completion is checked first so it beats the limit on a tie.
                    if (!bus.uart_busy && quiet_q == QUIET_LAST) begin
                        state_q  <= FINISHING;
                        finish_q <= 1'b1;
                    end else if (drain_q == DRAIN_LAST) begin
                        state_q   <= FINISHING;
                        finish_q  <= 1'b1;
                        timeout_q <= 1'b1;
                        // A zero code would report a pass despite a stuck UART.
                        if (code_q == '0) begin
                            code_q <= FORCED;
                        end
                    end
                    quiet_q <= bus.uart_busy ? '0 : quiet_q + 1'b1;
                    drain_q <= drain_q + 1'b1;
                end
                FINISHING: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= DONE;
                end
            endcase
            // Any request once a winner exists is flagged; the winner never changes.
            if (state_q != RUNNING && |bus.end_request) begin
                late_q <= 1'b1;
            end
        end
    end

    assign bus.ending        = ending_q;
    assign bus.finish_pulse  = finish_q;
    assign bus.winner_index  = winner_q;
    assign bus.exit_code     = code_q;
    assign bus.drain_timeout = timeout_q;
    assign bus.late_request  = late_q;

endmodule

// File: tb/tb_simulation_end_controller.sv
// Directed bench for the end-of-simulation sequencer.
// Latency: n/a.
// Backpressure: n/a.
module tb_simulation_end_controller;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    simulation_end_controller_if bus ();

    simulation_end_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_code(input int i, input logic [7:0] c);
        bus.end_exit_codes[i*8 +: 8] = c;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.end_request = '0;
        bus.uart_busy = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Steps until finish_pulse is seen or the budget runs out; n = edges taken.
    task automatic wait_finish(input int limit, output int n);
        n = 0;
        while (bus.finish_pulse !== 1'b1 && n < limit) begin
            step();
            n++;
        end
    endtask

    task automatic request(input logic [3:0] req);
        bus.end_request = req;
        step();
        bus.end_request = '0;
    endtask

    initial begin
        int n;
        int k;
        int pulses;

        bus.end_request    = '0;
        bus.end_exit_codes = 32'hA3B2_C1D0;
        bus.uart_busy      = 1'b0;

        // Reset state
        do_reset();
        check("rst_ending",  bus.ending,        0);
        check("rst_finish",  bus.finish_pulse,  0);
        check("rst_winner",  bus.winner_index,  0);
        check("rst_code",    bus.exit_code,     0);
        check("rst_timeout", bus.drain_timeout, 0);
        check("rst_late",    bus.late_request,  0);

        // Single request, quiet UART
        set_code(2, 8'h00);
        request(4'b0100);
        check("t1_ending", bus.ending, 1);
        check("t1_finish_early", bus.finish_pulse, 0);
        wait_finish(100, n);
        check("t1_latency", n, 16);
        check("t1_winner",  bus.winner_index, 2);
        check("t1_code",    bus.exit_code, 8'h00);
        check("t1_timeout", bus.drain_timeout, 0);
        check("t1_late",    bus.late_request, 0);
        step();
        check("t1_pulse_width", bus.finish_pulse, 0);
        step();
        step();
        check("t1_done_no_pulse", bus.finish_pulse, 0);
        check("t1_done_ending",   bus.ending, 1);
        check("t1_done_winner",   bus.winner_index, 2);

        // Simultaneous requests: lowest index wins
        do_reset();
        set_code(1, 8'h05);
        set_code(3, 8'h09);
        request(4'b1010);
        check("t2_winner", bus.winner_index, 1);
        check("t2_code",   bus.exit_code, 8'h05);
        check("t2_late",   bus.late_request, 0);
        wait_finish(100, n);
        check("t2_latency", n, 16);

        // Busy UART during DRAINING cycles 5..9 restarts the quiet window
        do_reset();
        set_code(0, 8'h22);
        request(4'b0001);
        k = 0;
        while (bus.finish_pulse !== 1'b1 && k < 200) begin
            k++;
            bus.uart_busy = (k >= 5 && k <= 9);
            step();
            if (k == 4) check("t3_quiet_before_busy", dut.quiet_q, 4);
            if (k == 9) check("t3_quiet_after_busy",  dut.quiet_q, 0);
        end
        bus.uart_busy = 1'b0;
        check("t3_latency", k, 25);
        check("t3_code",    bus.exit_code, 8'h22);
        check("t3_timeout", bus.drain_timeout, 0);

        // Stuck UART with a zero code: forced to 1
        do_reset();
        set_code(2, 8'h00);
        bus.uart_busy = 1'b1;
        request(4'b0100);
        wait_finish(2000, n);
        check("t4_latency", n, 1024);
        check("t4_timeout", bus.drain_timeout, 1);
        check("t4_code",    bus.exit_code, 8'h01);

        // Stuck UART with a non-zero code: kept
        do_reset();
        set_code(0, 8'h33);
        bus.uart_busy = 1'b1;
        request(4'b0001);
        wait_finish(2000, n);
        check("t5_latency", n, 1024);
        check("t5_timeout", bus.drain_timeout, 1);
        check("t5_code",    bus.exit_code, 8'h33);

        // Quiet completes on the same edge as the drain limit: quiet wins
        do_reset();
        set_code(2, 8'h00);
        request(4'b0100);
        k = 0;
        while (bus.finish_pulse !== 1'b1 && k < 2000) begin
            k++;
            bus.uart_busy = (k <= 1008);
            step();
        end
        bus.uart_busy = 1'b0;
        check("t6_latency", k, 1024);
        check("t6_timeout", bus.drain_timeout, 0);
        check("t6_code",    bus.exit_code, 8'h00);

        // Late request, then reset mid-drain, then a fresh sequence
        do_reset();
        set_code(2, 8'h11);
        set_code(0, 8'h44);
        request(4'b0100);
        step();
        step();
        step();
        request(4'b0001);
        check("t7_late",   bus.late_request, 1);
        check("t7_winner", bus.winner_index, 2);
        check("t7_code",   bus.exit_code, 8'h11);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t7_rst_ending", bus.ending, 0);
        check("t7_rst_late",   bus.late_request, 0);
        check("t7_rst_winner", bus.winner_index, 0);
        check("t7_rst_code",   bus.exit_code, 0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.finish_pulse === 1'b1) pulses++;
        end
        check("t7_no_finish", pulses, 0);
        set_code(3, 8'h07);
        request(4'b1000);
        wait_finish(100, n);
        check("t7_restart_latency", n, 16);
        check("t7_restart_winner",  bus.winner_index, 3);
        check("t7_restart_code",    bus.exit_code, 8'h07);
        check("t7_restart_late",    bus.late_request, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
